// File: rtl/timer_pkg.sv
// timer_pkg: shared types, digit limits and helpers for the countdown timer controller.
//   state_e  - controller states
//   DIGIT_W  - bits per BCD digit
//   MAX_DIGIT/MAX_TENS - largest legal digit / largest legal seconds-tens digit
package timer_pkg;

    localparam int DIGIT_W   = 4;
    localparam int MAX_DIGIT = 9;
    localparam int MAX_TENS  = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_RUNNING,
        S_PAUSED,
        S_DONE
    } state_e;

    function automatic logic is_digit(input logic [DIGIT_W-1:0] k);
        return k <= DIGIT_W'(MAX_DIGIT);
    endfunction

    // Seconds-tens digit of a {min_tens, min_ones, sec_tens, sec_ones} word.
    function automatic logic [DIGIT_W-1:0] sec_tens(input logic [4*DIGIT_W-1:0] d);
        return d[2*DIGIT_W-1:DIGIT_W];
    endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler producing a one-cycle tick every TICK_DIV counted cycles.
//   clock - rising-edge clock
//   clrn  - asynchronous active-low reset
//   run   - advance the prescaler this cycle (holds its value when low)
//   clr   - synchronous zero of the prescaler, overrides run
//   tick  - high in the cycle the prescaler sits at TICK_DIV-1 while running
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clock,
    input  logic clrn,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr ? '0 : !run ? cnt_q : (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick = run && !clr && (cnt_q == LAST);

endmodule

// File: rtl/timer_control.sv
// timer_control: keypad-loaded countdown timer controller driving a BCD counter chain.
//   clock, clrn        - clock and asynchronous active-low reset
//   key_valid/key_data - keypad strobe and code (0-9 digits, others ignored)
//   start, stop, clear - command pulses, priority clear > stop > start > key
//   zero_all           - counter chain reads all zeros
//   data, loadn        - load value and active-low load strobe for the chain
//   enable             - one-cycle count-down tick
//   cnt_clrn           - active-low clear pulse for the chain
//   running, done, err - status flags
module timer_control
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                 clock,
    input  logic                 clrn,
    input  logic                 key_valid,
    input  logic [DIGIT_W-1:0]   key_data,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 clear,
    input  logic                 zero_all,
    output logic [4*DIGIT_W-1:0] data,
    output logic                 loadn,
    output logic                 enable,
    output logic                 cnt_clrn,
    output logic                 running,
    output logic                 done,
    output logic                 err
);

    state_e               state_q, state_d;
    logic [4*DIGIT_W-1:0] data_q, data_d;
    logic                 loadn_q, loadn_d;
    logic                 cnt_clrn_q, cnt_clrn_d;
    logic                 err_q, err_d;
    logic                 tick_run, tick_clr, tick;

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            loadn_q    <= 1'b1;
            cnt_clrn_q <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            loadn_q    <= loadn_d;
            cnt_clrn_q <= cnt_clrn_d;
            err_q      <= err_d;
        end
    end

    // The load cycle (loadn_q low) is a one-cycle tail of ENTRY; only clear can abort it.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        loadn_d    = 1'b1;
        cnt_clrn_d = 1'b1;
        err_d      = 1'b0;
        if (clear) begin
            state_d    = S_IDLE;
            data_d     = '0;
            cnt_clrn_d = 1'b0;
        end else if (!loadn_q) begin
            state_d = S_RUNNING;
        end else if (stop) begin
            if (state_q == S_RUNNING) state_d = S_PAUSED;
        end else if (state_q == S_RUNNING) begin
            if (zero_all) state_d = S_DONE;
        end else if (state_q == S_PAUSED) begin
            if (start) state_d = S_RUNNING;
        end else if (start && state_q == S_DONE) begin
            state_d = S_IDLE;
        end else if (start && state_q == S_ENTRY && data_q != '0) begin
            if (sec_tens(data_q) > DIGIT_W'(MAX_TENS)) err_d   = 1'b1;
            else                                        loadn_d = 1'b0;
        end else if (key_valid && is_digit(key_data)) begin
            data_d  = {data_q[3*DIGIT_W-1:0], key_data};
            state_d = S_ENTRY;
        end
    end

    // Suppressing the tick when zero_all is high keeps the chain from wrapping 0 -> 9.
    // A fresh load restarts the prescaler; a resume from PAUSED does not.
    assign tick_run = (state_q == S_RUNNING) && !stop && !zero_all;
    assign tick_clr = clear || !loadn_q;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock(clock),
        .clrn (clrn),
        .run  (tick_run),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_comb begin
        data     = data_q;
        loadn    = loadn_q;
        cnt_clrn = cnt_clrn_q;
        err      = err_q;
        enable   = tick;
        running  = state_q == S_RUNNING;
        done     = state_q == S_DONE;
    end

endmodule

// File: tb/tb_timer_control.sv
// tb_timer_control: directed self-checking bench for timer_control with TICK_DIV = 4.
module tb_timer_control;
    import timer_pkg::*;

    logic        clock = 1'b0;
    logic        clrn = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_data = 4'd0;
    logic        start = 1'b0, stop = 1'b0, clear = 1'b0, zero_all = 1'b0;
    logic [15:0] data;
    logic        loadn, enable, cnt_clrn, running, done, err;
    int          n_cmp = 0;
    int          n_err = 0;

    timer_control #(.TICK_DIV(4)) dut (
        .clock(clock), .clrn(clrn), .key_valid(key_valid), .key_data(key_data),
        .start(start), .stop(stop), .clear(clear), .zero_all(zero_all),
        .data(data), .loadn(loadn), .enable(enable), .cnt_clrn(cnt_clrn),
        .running(running), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_data  = k;
        @(negedge clock);
        key_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        n_cmp++; if (data !== 16'h0000) begin n_err++; $display("FAIL reset_data: got %h want 0000", data); end
        n_cmp++; if ({loadn, cnt_clrn} !== 2'b11) begin n_err++; $display("FAIL reset_strobes: got %b want 11", {loadn, cnt_clrn}); end
        n_cmp++; if ({enable, running, done, err} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {enable, running, done, err}); end
        clrn = 1'b1;
        @(negedge clock);
        n_cmp++; if (dut.state_q !== S_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, S_IDLE); end
    endtask

    task automatic test_load;
        press(4'd1);
        n_cmp++; if (data !== 16'h0001) begin n_err++; $display("FAIL load_key1: got %h want 0001", data); end
        press(4'd3);
        press(4'd0);
        n_cmp++; if (data !== 16'h0130) begin n_err++; $display("FAIL load_data: got %h want 0130", data); end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_cmp++; if ({loadn, running} !== 2'b00) begin n_err++; $display("FAIL load_strobe: got loadn,running=%b want 00", {loadn, running}); end
        @(negedge clock);
        n_cmp++; if ({loadn, running} !== 2'b11) begin n_err++; $display("FAIL load_run: got loadn,running=%b want 11", {loadn, running}); end
    endtask

    task automatic test_count;
        for (int i = 0; i < 12; i++) begin
            n_cmp++; if (enable !== (i % 4 == 3)) begin n_err++; $display("FAIL count_enable[%0d]: got %b want %b", i, enable, (i % 4 == 3)); end
            @(negedge clock);
        end
    endtask

    task automatic test_pause;
        repeat (2) @(negedge clock);
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        n_cmp++; if (dut.state_q !== S_PAUSED || running !== 1'b0) begin n_err++; $display("FAIL pause_state: got %0d/%b want %0d/0", dut.state_q, running, S_PAUSED); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            n_cmp++; if (enable !== 1'b0) begin n_err++; $display("FAIL pause_enable[%0d]: got %b want 0", i, enable); end
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_cmp++; if ({running, enable, loadn} !== 3'b101) begin n_err++; $display("FAIL resume_1: got run,en,loadn=%b want 101", {running, enable, loadn}); end
        @(negedge clock);
        n_cmp++; if (enable !== 1'b1) begin n_err++; $display("FAIL resume_2: got %b want 1", enable); end
        @(negedge clock);
        n_cmp++; if (enable !== 1'b0) begin n_err++; $display("FAIL resume_3: got %b want 0", enable); end
    endtask

    task automatic test_done;
        repeat (3) @(negedge clock);
        n_cmp++; if (enable !== 1'b1) begin n_err++; $display("FAIL done_pre: got %b want 1", enable); end
        zero_all = 1'b1;
        #1;
        n_cmp++; if (enable !== 1'b0) begin n_err++; $display("FAIL done_suppress: got %b want 0", enable); end
        @(negedge clock);
        n_cmp++; if ({done, running} !== 2'b10) begin n_err++; $display("FAIL done_state: got done,running=%b want 10", {done, running}); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_cmp++; if ({done, enable} !== 2'b10) begin n_err++; $display("FAIL done_hold[%0d]: got done,en=%b want 10", i, {done, enable}); end
        end
        zero_all = 1'b0;
    endtask

    task automatic test_err;
        press(4'd0);
        n_cmp++; if (dut.state_q !== S_ENTRY || data !== 16'h1300) begin n_err++; $display("FAIL err_key0: got %0d/%h want %0d/1300", dut.state_q, data, S_ENTRY); end
        press(4'd7);
        press(4'd5);
        n_cmp++; if (data !== 16'h0075) begin n_err++; $display("FAIL err_data: got %h want 0075", data); end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_cmp++; if ({err, loadn} !== 2'b11) begin n_err++; $display("FAIL err_pulse: got err,loadn=%b want 11", {err, loadn}); end
        @(negedge clock);
        n_cmp++; if ({err, loadn, running} !== 3'b010) begin n_err++; $display("FAIL err_after: got err,loadn,run=%b want 010", {err, loadn, running}); end
        n_cmp++; if (dut.state_q !== S_ENTRY) begin n_err++; $display("FAIL err_state: got %0d want %0d", dut.state_q, S_ENTRY); end
    endtask

    task automatic test_clear_start;
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        n_cmp++; if ({cnt_clrn, data} !== {1'b0, 16'h0000}) begin n_err++; $display("FAIL clear_idle: got %b/%h want 0/0000", cnt_clrn, data); end
        @(negedge clock);
        n_cmp++; if (cnt_clrn !== 1'b1) begin n_err++; $display("FAIL clear_release: got %b want 1", cnt_clrn); end
        press(4'd2);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL cs_running: got %b want 1", running); end
        @(negedge clock);
        clear = 1'b1;
        start = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        start = 1'b0;
        n_cmp++; if (dut.state_q !== S_IDLE || running !== 1'b0) begin n_err++; $display("FAIL cs_state: got %0d/%b want %0d/0", dut.state_q, running, S_IDLE); end
        n_cmp++; if ({cnt_clrn, loadn, data} !== {2'b01, 16'h0000}) begin n_err++; $display("FAIL cs_outputs: got %b %b %h want 0 1 0000", cnt_clrn, loadn, data); end
        @(negedge clock);
        n_cmp++; if ({cnt_clrn, loadn, enable} !== 3'b110) begin n_err++; $display("FAIL cs_after: got %b want 110", {cnt_clrn, loadn, enable}); end
    endtask

    task automatic test_bad_key;
        press(4'd12);
        n_cmp++; if (data !== 16'h0000 || dut.state_q !== S_IDLE) begin n_err++; $display("FAIL badkey_12: got %h/%0d want 0000/%0d", data, dut.state_q, S_IDLE); end
        press(4'd15);
        n_cmp++; if (data !== 16'h0000 || dut.state_q !== S_IDLE) begin n_err++; $display("FAIL badkey_15: got %h/%0d want 0000/%0d", data, dut.state_q, S_IDLE); end
    endtask

    task automatic test_async_reset;
        press(4'd4);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        repeat (3) @(negedge clock);
        n_cmp++; if ({running, enable} !== 2'b11) begin n_err++; $display("FAIL ar_pre: got run,en=%b want 11", {running, enable}); end
        clrn = 1'b0;
        #1;
        n_cmp++; if ({enable, running, done, err} !== 4'b0000) begin n_err++; $display("FAIL ar_flags: got %b want 0000", {enable, running, done, err}); end
        n_cmp++; if ({loadn, cnt_clrn, data} !== {2'b11, 16'h0000}) begin n_err++; $display("FAIL ar_outputs: got %b %b %h want 1 1 0000", loadn, cnt_clrn, data); end
        @(negedge clock);
        clrn = 1'b1;
        @(negedge clock);
        n_cmp++; if (dut.state_q !== S_IDLE || enable !== 1'b0) begin n_err++; $display("FAIL ar_release: got %0d/%b want %0d/0", dut.state_q, enable, S_IDLE); end
    endtask

    initial begin
        test_reset;
        test_load;
        test_count;
        test_pause;
        test_done;
        test_err;
        test_clear_start;
        test_bad_key;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
